// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle main control FSM: state codes,
// instruction classes and the datapath select values it drives.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_ALU_WB  = 4'd7,
        S_MEM_WB  = 4'd8,
        S_BRANCH  = 4'd9,
        S_ERROR   = 4'd10
    } state_t;

    // Instruction class (tipo) and the I-type op that selects LOAD
    localparam logic [1:0] TIPO_R = 2'b00;
    localparam logic [1:0] TIPO_I = 2'b01;
    localparam logic [1:0] TIPO_S = 2'b10;
    localparam logic [1:0] TIPO_B = 2'b11;
    localparam logic [1:0] OP_LOAD = 2'b00;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALU_B_REG  = 2'b00;
    localparam logic [1:0] ALU_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_B_FOUR = 2'b10;

    // Immediate extender select
    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_IS   = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;

    // States that sit on the shared memory waiting for mem_ready
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready and flags when the
// count reaches the timeout threshold. Hold has priority over clear/count
// so a stalled FSM keeps its wait budget intact.
module mem_wait_timer
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    input  logic count,
    output logic timeout
);

    logic [WAIT_W-1:0] wait_cnt;

    assign timeout = (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    // Wait counter: reset, then hold, then clear, then saturating increment
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (hold)
            wait_cnt <= wait_cnt;
        else if (clear)
            wait_cnt <= '0;
        else if (count && !timeout)
            wait_cnt <= wait_cnt + 1'b1;
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback over a
// shared memory with a mem_ready handshake, stall freeze and a sticky
// memory-timeout error state.
module multicycle_main_fsm
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tipo,
    input  logic [1:0] op,
    input  logic       inm,
    input  logic       cond_true,
    input  logic       mem_ready,
    input  logic       stall,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       result_src,
    output logic       instr_done,
    output logic       err,
    output logic [3:0] state_o
);

    state_t state, next_state;
    logic   timeout;
    logic   wait_clear, wait_count;

    // A wait only counts when nothing completes it and the FSM is not frozen
    assign wait_clear = !stall && (next_state != state);
    assign wait_count = !stall && is_wait_state(state) && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .WAIT_W     (WAIT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (wait_clear),
        .hold   (stall),
        .count  (wait_count),
        .timeout(timeout)
    );

    // Next-state logic; stall freezes the FSM, mem_ready beats timeout
    always_comb begin
        next_state = state;
        if (!stall) begin
            case (state)
                S_FETCH:   if (mem_ready) next_state = S_DECODE;
                           else if (timeout) next_state = S_ERROR;
                S_DECODE: begin
                    case (tipo)
                        TIPO_R:  next_state = S_EXEC_R;
                        TIPO_I:  next_state = (op == OP_LOAD) ? S_MEM_ADR : S_EXEC_I;
                        TIPO_S:  next_state = S_MEM_ADR;
                        default: next_state = S_BRANCH;
                    endcase
                end
                S_EXEC_R:  next_state = S_ALU_WB;
                S_EXEC_I:  next_state = S_ALU_WB;
                S_MEM_ADR: next_state = (tipo == TIPO_S) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:  if (mem_ready) next_state = S_MEM_WB;
                           else if (timeout) next_state = S_ERROR;
                S_MEM_WR:  if (mem_ready) next_state = S_FETCH;
                           else if (timeout) next_state = S_ERROR;
                S_ALU_WB:  next_state = S_FETCH;
                S_MEM_WB:  next_state = S_FETCH;
                S_BRANCH:  next_state = S_FETCH;
                S_ERROR:   next_state = S_ERROR;
                default:   next_state = S_FETCH;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Sticky error flag, raised together with entry into S_ERROR
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (next_state == S_ERROR)
            err <= 1'b1;
    end

    assign state_o = state;

    // Output decode from registered state; reset blanks everything and
    // stall suppresses every write-type strobe while mem_read/selects hold
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        imm_src    = IMM_NONE;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_B_REG;
        alu_op     = ALUOP_ADD;
        result_src = 1'b0;
        instr_done = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALU_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    case (tipo)
                        TIPO_R:  imm_src = inm ? IMM_IS : IMM_NONE;
                        TIPO_B:  imm_src = IMM_BR;
                        default: imm_src = IMM_IS;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = inm ? ALU_B_IMM : ALU_B_REG;
                    alu_op    = ALUOP_FUNCT;
                end
                S_EXEC_I, S_MEM_ADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_B_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    adr_src  = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    adr_src    = 1'b1;
                    instr_done = mem_ready;
                end
                S_ALU_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    result_src = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_b  = ALU_B_IMM;
                    imm_src    = IMM_BR;
                    alu_op     = ALUOP_BR;
                    pc_write   = cond_true;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
            if (stall) begin
                pc_write   = 1'b0;
                ir_write   = 1'b0;
                mem_write  = 1'b0;
                reg_write  = 1'b0;
                instr_done = 1'b0;
            end
        end
    end

endmodule
